// File: rtl/alimentador_programa_if.sv
// Feeder bundle: program loader side, processor DIN/Run/Done side and status.
// master = feeder, slave = loader/processor (or bench).
interface alimentador_programa_if #(parameter int AW = 4);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          Done;
  logic [15:0]   BusWires;
  logic [15:0]   DIN;
  logic          Run;
  logic          busy;
  logic          finished;
  logic [7:0]    instr_count;
  logic [15:0]   last_bus;
  logic          timeout_err;

  modport master (
    input  prog_we, prog_addr, prog_data, prog_len, start, Done, BusWires,
    output DIN, Run, busy, finished, instr_count, last_bus, timeout_err
  );
  modport slave (
    output prog_we, prog_addr, prog_data, prog_len, start, Done, BusWires,
    input  DIN, Run, busy, finished, instr_count, last_bus, timeout_err
  );
endinterface

// File: rtl/alimentador_programa.sv
// Program feeder for processador_multiciclo: issues stored words on DIN/Run, one per Done.
// Optional Done watchdog enabled by defining FEEDER_TIMEOUT_EN.
module alimentador_programa #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input logic                   i_clk,
  input logic                   i_rst,
  alimentador_programa_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_IMM, S_FINISH} state_t;

  state_t      r_state;
  logic [15:0] r_mem [DEPTH];
  logic [AW:0] r_pc, r_len;
  logic [15:0] r_din, r_last;
  logic        r_run, r_busy, r_finished, r_terr;
  logic [7:0]  r_cnt;

  logic [AW:0] w_pc1, w_npc, w_clamp;
  logic [15:0] w_cur, w_imm, w_nxt;

  assign w_pc1   = r_pc + (AW+1)'(1);
  // After Done, mvi consumes its immediate word as well
  assign w_npc   = (r_state == S_IMM) ? r_pc + (AW+1)'(2) : w_pc1;
  assign w_cur   = r_mem[r_pc[AW-1:0]];
  assign w_imm   = (w_pc1 < r_len) ? r_mem[w_pc1[AW-1:0]] : 16'h0000;
  assign w_nxt   = r_mem[w_npc[AW-1:0]];
  assign w_clamp = (bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.prog_len;

  always_ff @(posedge i_clk) begin
    if (bus.prog_we && r_state == S_IDLE) r_mem[bus.prog_addr] <= bus.prog_data;
  end

`ifdef FEEDER_TIMEOUT_EN
  logic [15:0] r_wd;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_din      <= '0;
      r_last     <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_terr     <= 1'b0;
      r_cnt      <= '0;
      r_pc       <= '0;
      r_len      <= '0;
`ifdef FEEDER_TIMEOUT_EN
      r_wd       <= '0;
`endif
    end else begin
      r_run      <= 1'b0;
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_din <= '0;
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.prog_len == '0) begin
              r_state    <= S_FINISH;
              r_finished <= 1'b1;
            end else begin
              r_len   <= w_clamp;
              r_pc    <= '0;
              r_cnt   <= '0;
              r_state <= S_ISSUE;
              r_run   <= 1'b1;
              r_din   <= r_mem[0];
            end
          end
        end
        S_ISSUE: begin
`ifdef FEEDER_TIMEOUT_EN
          r_wd <= '0;
`endif
          if (w_cur[8:6] == 3'b001) begin
            r_state <= S_IMM;
            r_din   <= w_imm;
          end else begin
            r_state <= S_WAIT;
            r_din   <= w_cur;
          end
        end
        S_WAIT, S_IMM: begin
          if (bus.Done) begin
            r_last <= bus.BusWires;
            r_cnt  <= r_cnt + 8'd1;
            r_pc   <= w_npc;
            if (w_npc < r_len) begin
              r_state <= S_ISSUE;
              r_run   <= 1'b1;
              r_din   <= w_nxt;
            end else begin
              r_state    <= S_FINISH;
              r_finished <= 1'b1;
              r_din      <= '0;
            end
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (r_wd == 16'(TIMEOUT - 1)) begin
            r_terr     <= 1'b1;
            r_state    <= S_FINISH;
            r_finished <= 1'b1;
            r_din      <= '0;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
`endif
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_din   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  assign bus.timeout_err = r_terr;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT ^ r_terr;
  assign bus.timeout_err  = 1'b0;
`endif

  assign bus.DIN         = r_din;
  assign bus.Run         = r_run;
  assign bus.busy        = r_busy;
  assign bus.finished    = r_finished;
  assign bus.instr_count = r_cnt;
  assign bus.last_bus    = r_last;
endmodule

// File: tb/tb_alimentador_programa.sv
// Bench for alimentador_programa: directed program table, reset/watchdog sequences,
// and random programs checked against a word-level issue model.
module tb_alimentador_programa;
  localparam int AW = 4, DEPTH = 16, TMO = 8;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  alimentador_programa_if #(.AW(AW)) bif();
  alimentador_programa #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bif)
  );

  int checks = 0, failures = 0;
  logic [15:0] mem_m [DEPTH];
  logic [15:0] q_run[$], q_wait[$];

  typedef struct {
    string       name;
    int          len;
    logic [15:0] w0, w1, w2, w3;
    bit          spur;
    int          exp_count;
  } vec_t;
  vec_t vec[7];

  function automatic vec_t mk(string n, int l, logic [15:0] a, logic [15:0] b,
                              logic [15:0] c, logic [15:0] d, bit s, int e);
    vec_t v;
    v.name = n; v.len = l; v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = d; v.spur = s; v.exp_count = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [15:0] d);
    bif.prog_we = 1'b1; bif.prog_addr = a[AW-1:0]; bif.prog_data = d;
    mem_m[a] = d;
    @(negedge clk);
    bif.prog_we = 1'b0;
  endtask

  // Word-level view: what DIN shows during each Run pulse and while waiting for its Done
  function automatic void build(input int plen);
    int L, pc;
    logic [15:0] w;
    L = (plen > DEPTH) ? DEPTH : plen;
    pc = 0;
    q_run.delete(); q_wait.delete();
    while (pc < L) begin
      w = mem_m[pc];
      q_run.push_back(w);
      if (w[8:6] == 3'b001) begin
        q_wait.push_back((pc + 1 < L) ? mem_m[pc+1] : 16'h0000);
        pc += 2;
      end else begin
        q_wait.push_back(w);
        pc += 1;
      end
    end
  endfunction

  task automatic exec(input int plen, input bit spur, input bit noise, input int maxlat);
    logic [15:0] bus_v;
    int n, lat;
    build(plen);
    n = q_run.size();
    bus_v = '0;
    bif.prog_len = plen[AW:0]; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("run_issue", bif.Run, 1);
      chk("din_issue", bif.DIN, q_run[i]);
      chk("busy_issue", bif.busy, 1);
      bif.Done = spur; bif.BusWires = 16'($urandom);
      @(negedge clk);
      bif.Done = 1'b0;
      lat = $urandom_range(0, maxlat);
      for (int k = 0; k <= lat; k++) begin
        chk("run_wait", bif.Run, 0);
        chk("din_wait", bif.DIN, q_wait[i]);
        if (k == lat) begin
          bus_v = 16'($urandom);
          bif.Done = 1'b1; bif.BusWires = bus_v; bif.prog_we = 1'b0; bif.start = 1'b0;
        end else if (noise) begin
          bif.prog_we   = 1'($urandom_range(0, 1));
          bif.prog_addr = AW'($urandom);
          bif.prog_data = 16'($urandom);
          bif.start     = 1'($urandom_range(0, 1));
          bif.prog_len  = (AW+1)'($urandom);
        end
        @(negedge clk);
      end
      bif.Done = 1'b0;
      chk("last_bus", bif.last_bus, bus_v);
      chk("instr_count", bif.instr_count, i + 1);
    end
    chk("finished_pulse", bif.finished, 1);
    chk("run_finish", bif.Run, 0);
    chk("busy_finish", bif.busy, 1);
    @(negedge clk);
    chk("finished_once", bif.finished, 0);
    chk("busy_idle", bif.busy, 0);
  endtask

  initial begin
    int plen;
    logic [15:0] w;
    bif.prog_we = 1'b0; bif.prog_addr = '0; bif.prog_data = '0; bif.prog_len = '0;
    bif.start = 1'b0; bif.Done = 1'b0; bif.BusWires = '0;

    vec[0] = mk("mv",        1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 1);
    vec[1] = mk("mvi",       2, 16'h0040, 16'h00AB, 16'h0000, 16'h0000, 0, 1);
    vec[2] = mk("seq3",      4, 16'h0001, 16'h0040, 16'h0055, 16'h0081, 0, 3);
    vec[3] = mk("mvi_tail",  1, 16'h0040, 16'h00AB, 16'h0000, 16'h0000, 0, 1);
    vec[4] = mk("tail3",     3, 16'h0001, 16'h0081, 16'h0040, 16'h1234, 1, 3);
    vec[5] = mk("len0",      0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    vec[6] = mk("seq3_spur", 4, 16'h0001, 16'h0040, 16'h0055, 16'h0081, 1, 3);

    repeat (2) @(negedge clk);
    chk("rst_din", bif.DIN, 0);
    chk("rst_run", bif.Run, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_finished", bif.finished, 0);
    chk("rst_count", bif.instr_count, 0);
    chk("rst_last_bus", bif.last_bus, 0);
    chk("rst_timeout", bif.timeout_err, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) load(i, 16'h0000);

    for (int t = 0; t < 7; t++) begin
      load(0, vec[t].w0); load(1, vec[t].w1); load(2, vec[t].w2); load(3, vec[t].w3);
      exec(vec[t].len, vec[t].spur, 1'b0, 3);
      if (vec[t].len != 0) chk({vec[t].name, "_count"}, bif.instr_count, vec[t].exp_count);
    end

    // Reset while the second instruction (mvi) waits for Done
    load(0, 16'h0001); load(1, 16'h0040); load(2, 16'h0055); load(3, 16'h0081);
    bif.prog_len = 5'd4; bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    @(negedge clk); bif.Done = 1'b1; bif.BusWires = 16'h00AA;
    @(negedge clk); bif.Done = 1'b0;
    chk("mid_run2", bif.Run, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_run", bif.Run, 0);
    chk("mid_rst_din", bif.DIN, 0);
    chk("mid_rst_busy", bif.busy, 0);
    chk("mid_rst_count", bif.instr_count, 0);
    chk("mid_rst_finished", bif.finished, 0);
    exec(4, 1'b0, 1'b0, 2);
    chk("rerun_count", bif.instr_count, 3);

    // Done never arrives
    load(0, 16'h0001);
    bif.prog_len = 5'd1; bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    chk("wd_issue", bif.Run, 1);
`ifdef FEEDER_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("wd_busy", bif.busy, 1);
      chk("wd_nofinish", bif.finished, 0);
    end
    @(negedge clk);
    chk("wd_finished", bif.finished, 1);
    chk("wd_err", bif.timeout_err, 1);
    @(negedge clk);
    chk("wd_idle", bif.busy, 0);
    chk("wd_sticky", bif.timeout_err, 1);
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk("nowd_busy", bif.busy, 1);
      chk("nowd_finished", bif.finished, 0);
    end
    chk("nowd_err", bif.timeout_err, 0);
`endif
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("wd_rst_err", bif.timeout_err, 0);
    chk("wd_rst_busy", bif.busy, 0);

    // Random programs; noisy writes/starts while busy must not disturb the rerun
    for (int r = 0; r < 25; r++) begin
      for (int j = 0; j < DEPTH; j++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 2) == 0) w[8:6] = 3'b001;
        load(j, w);
      end
      plen = $urandom_range(0, 20);
      exec(plen, 1'($urandom_range(0, 1)), 1'b1, 4);
      exec(plen, 1'b0, 1'b0, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alimentador_programa.md
Name: alimentador_programa

Overview:
- Initiator-side driver for processador_multiciclo: stores a short program in local memory and issues it word by word on DIN/Run.
- Waits for Done after each instruction, then advances to the next word.
- Captures BusWires at Done, for result logging on FPGA and for self-checking benches.
- Replaces hand-written DIN/Run stimulus; sits between the program loader (switches/bench) and the processor.

Parameters:
- DEPTH, 16: program memory words.
- AW, 4: address width, clog2(DEPTH).
- TIMEOUT, 64: max cycles waiting for Done (used only with the optional feature).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- prog_we  in  1  memory write strobe; honoured only in IDLE.
- prog_addr  in  AW  write address.
- prog_data  in  16  write data (instruction or immediate word).
- prog_len  in  AW+1  number of valid words; sampled on start.
- start  in  1  begin execution from address 0; honoured only in IDLE.
- Done  in  1  processor instruction-complete flag.
- BusWires  in  16  processor bus, sampled when Done=1.
- DIN  out  16  word presented to the processor.
- Run  out  1  one-cycle issue strobe.
- busy  out  1  high in any state except IDLE.
- finished  out  1  one-cycle pulse when the program ends.
- instr_count  out  8  instructions completed since start; wraps 255->0.
- last_bus  out  16  BusWires value captured at the most recent Done.
- timeout_err  out  1  sticky watchdog flag; constant 0 without the macro.

Behaviour:
- Reset:
  - State goes to IDLE.
  - DIN, last_bus = 16'h0000; instr_count = 0.
  - Run, busy, finished, timeout_err = 0; pc = 0.
  - Memory contents are not cleared.
  - A reset mid-program aborts it immediately: Run=0 on the next cycle, no finished pulse.
- Memory: synchronous write when prog_we && state==IDLE; writes in other states are dropped. Reads are combinational.
- States: IDLE, ISSUE, WAIT, IMM, FINISH.
- IDLE:
  - DIN=0, Run=0.
  - start with prog_len==0: go to FINISH.
  - start with prog_len>DEPTH: clamp to DEPTH.
  - Otherwise latch len, set pc=0, instr_count=0, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Run=1, DIN=mem[pc].
  - Done is ignored in this cycle.
  - Next state is IMM if mem[pc][8:6]==3'b001 (mvi), else WAIT.
- WAIT:
  - Run=0, DIN held at mem[pc].
  - On Done: last_bus<=BusWires, instr_count++, pc<=pc+1.
- IMM:
  - Run=0, DIN=mem[pc+1], or 16'h0000 if pc+1>=len.
  - On Done: last_bus<=BusWires, instr_count++, pc<=pc+2.
- After Done in WAIT/IMM: next state is ISSUE if the new pc<len, else FINISH.
- FINISH (1 cycle): finished=1, busy=1, then IDLE.
- Latency: Run pulses on the cycle after start is sampled. The next Run pulses on the cycle after Done is sampled.
- A start pulse while busy is ignored.

Optional Feature:
- Macro FEEDER_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT/IMM and increments each cycle there.
  - If it reaches TIMEOUT without Done: timeout_err<=1 (sticky until Reset), go to FINISH, finished pulses.
- Undefined: no counter; timeout_err tied 0; WAIT/IMM wait indefinitely.

Test Plan:
- Single mv:
  - Load mem[0]=16'h0001 (mv R0,R1), prog_len=1; pulse start.
  - Run=1 for exactly one cycle with DIN=16'h0001.
  - Model asserts Done 3 cycles later with BusWires=16'd10.
  - Expect last_bus=10, instr_count=1, one finished pulse, busy low the cycle after.
- mvi immediate:
  - mem[0]=16'h0040 (mvi R0), mem[1]=16'h00AB, prog_len=2.
  - DIN=16'h0040 during Run, then 16'h00AB until Done.
  - instr_count=1, pc ends at 2, finished pulses.
- Three-instruction sequence:
  - mv, mvi+imm, add (4 words).
  - Exactly 3 Run pulses, each one cycle after the prior Done.
  - instr_count=3; last_bus equals the BusWires of the 3rd Done.
- Boundary cases:
  - Done asserted during the ISSUE cycle is ignored.
  - Trailing mvi at the last address presents DIN=0.
  - prog_len=0 gives finished one cycle after start, with no Run.
  - prog_we while busy leaves memory unchanged.
- Reset mid-op:
  - Assert Reset while in WAIT.
  - Next cycle: Run=0, DIN=0, busy=0, instr_count=0, no finished pulse.
  - Memory still holds the program; a new start reruns it identically.
- Watchdog (FEEDER_TIMEOUT_EN, TIMEOUT=8):
  - Never assert Done.
  - timeout_err=1 and finished pulses 8 cycles after entering WAIT.
  - Without the macro, busy stays high indefinitely.
